// File: rtl/booth_r4_seq_ctrl_if.sv
// Handshake and adder bus for booth_r4_seq_ctrl; is_signed exists only with BOOTH_UNSIGNED_EN.
// master = operand producer / product consumer / adder side, slave = the multiplier.
interface booth_r4_seq_ctrl_if #(
    parameter int WIDTH = 64
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     x_in;
    logic [WIDTH-1:0]     y_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic [WIDTH+1:0]     add_a;
    logic [WIDTH+1:0]     add_b;
    logic [WIDTH+1:0]     add_s;
`ifdef BOOTH_UNSIGNED_EN
    logic                 is_signed;

    modport master (
        output in_valid, x_in, y_in, out_ready, add_s, is_signed,
        input  in_ready, out_valid, product, add_a, add_b
    );
    modport slave (
        input  in_valid, x_in, y_in, out_ready, add_s, is_signed,
        output in_ready, out_valid, product, add_a, add_b
    );
`else
    modport master (
        output in_valid, x_in, y_in, out_ready, add_s,
        input  in_ready, out_valid, product, add_a, add_b
    );
    modport slave (
        input  in_valid, x_in, y_in, out_ready, add_s,
        output in_ready, out_valid, product, add_a, add_b
    );
`endif
endinterface

// File: rtl/booth_r4_seq_ctrl.sv
// Sequential radix-4 Booth multiplier driving an external WIDTH+2 adder; BOOTH_UNSIGNED_EN adds is_signed.
// Latency: out_valid in cycle ITER+1 after the handshake (ITER+2 for unsigned).
// Backpressure: product held in DONE until out_ready; in_ready only in IDLE.
module booth_r4_seq_ctrl #(
    parameter int WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    booth_r4_seq_ctrl_if.slave   bus
);
    localparam int ITER = WIDTH / 2;
    localparam int AW   = WIDTH + 2;
`ifdef BOOTH_UNSIGNED_EN
    localparam int QW   = WIDTH + 2;
`else
    localparam int QW   = WIDTH;
`endif
    localparam int CW   = $clog2(ITER + 2);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t               r_state;
    logic [AW-1:0]        r_acc, r_m1, r_m2, r_n1, r_n2;
    logic [QW-1:0]        r_q;
    logic                 r_qm1;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_product;
    logic                 r_out_valid;

    logic [2:0]           w_digit;
    logic [AW-1:0]        w_pp;
    logic [AW+QW-1:0]     w_shift;
    logic [AW-1:0]        w_acc_nxt;
    logic [QW-1:0]        w_q_nxt;
    logic [2*WIDTH-1:0]   w_prod;
    logic [CW-1:0]        w_last;
    logic                 w_sx;
    logic [AW-1:0]        w_m1_ld;
    logic [QW-1:0]        w_q_ld;

`ifdef BOOTH_UNSIGNED_EN
    logic                 r_signed;
    assign w_sx   = bus.is_signed & bus.x_in[WIDTH-1];
    assign w_q_ld = {2'b00, bus.y_in};
    assign w_last = r_signed ? CW'(ITER - 1) : CW'(ITER);
    // Signed runs stop with the two padding bits of Q still unconsumed at its bottom.
    assign w_prod = r_signed ? {w_acc_nxt[WIDTH-1:0], w_q_nxt[QW-1:2]}
                             : {w_acc_nxt[WIDTH-3:0], w_q_nxt};
`else
    assign w_sx   = bus.x_in[WIDTH-1];
    assign w_q_ld = bus.y_in;
    assign w_last = CW'(ITER - 1);
    assign w_prod = {w_acc_nxt[WIDTH-1:0], w_q_nxt};
`endif

    assign w_m1_ld = {{2{w_sx}}, bus.x_in};
    assign w_digit = {r_q[1:0], r_qm1};

    always_comb begin
        w_pp = '0;
        case (w_digit)
            3'b001, 3'b010: w_pp = r_m1;
            3'b011:         w_pp = r_m2;
            3'b100:         w_pp = r_n2;
            3'b101, 3'b110: w_pp = r_n1;
            default:        w_pp = '0;
        endcase
    end

    // Adder inputs are forced to zero outside CALC so it stays quiet.
    assign bus.add_a = (r_state == S_CALC) ? r_acc : '0;
    assign bus.add_b = (r_state == S_CALC) ? w_pp  : '0;

    assign w_shift   = {{2{bus.add_s[AW-1]}}, bus.add_s, r_q[QW-1:2]};
    assign w_acc_nxt = w_shift[AW+QW-1:QW];
    assign w_q_nxt   = w_shift[QW-1:0];

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.product   = r_product;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_m1        <= '0;
            r_m2        <= '0;
            r_n1        <= '0;
            r_n2        <= '0;
            r_q         <= '0;
            r_qm1       <= 1'b0;
            r_cnt       <= '0;
            r_product   <= '0;
            r_out_valid <= 1'b0;
`ifdef BOOTH_UNSIGNED_EN
            r_signed    <= 1'b1;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_acc   <= '0;
                        r_q     <= w_q_ld;
                        r_qm1   <= 1'b0;
                        r_cnt   <= '0;
                        r_m1    <= w_m1_ld;
                        r_m2    <= w_m1_ld << 1;
                        r_n1    <= -w_m1_ld;
                        r_n2    <= (-w_m1_ld) << 1;
`ifdef BOOTH_UNSIGNED_EN
                        r_signed <= bus.is_signed;
`endif
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_nxt;
                    r_q   <= w_q_nxt;
                    r_qm1 <= r_q[1];
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == w_last) begin
                        r_product   <= w_prod;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_booth_r4_seq_ctrl.sv
// Directed bench for booth_r4_seq_ctrl with a behavioural adder closing the add_a/add_b/add_s loop.
module tb_booth_r4_seq_ctrl;
    localparam int W = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    booth_r4_seq_ctrl_if #(.WIDTH(W)) bus ();
    assign bus.add_s = bus.add_a + bus.add_b;

    booth_r4_seq_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Starts at a negedge in IDLE; returns at the negedge where out_valid is first seen.
    task automatic run_op(input string tag, input logic [63:0] x, input logic [63:0] y,
                          input logic sgn, input bit junk, input logic [127:0] exp, input int lat);
        int cyc;
        bus.x_in     = x;
        bus.y_in     = y;
`ifdef BOOTH_UNSIGNED_EN
        bus.is_signed = sgn;
`endif
        bus.in_valid = 1'b1;
        @(negedge clk);
        cyc = 1;
        if (junk) begin
            bus.x_in = ~x;
            bus.y_in = 64'd9;
        end else begin
            bus.in_valid = 1'b0;
        end
        check({tag, "_rdy_calc"}, {127'd0, bus.in_ready}, 128'd0);
        while (!bus.out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (cyc == 4) bus.in_valid = 1'b0;
        end
        check({tag, "_lat"}, 128'(cyc), 128'(lat));
        check({tag, "_prod"}, bus.product, exp);
        check({tag, "_rdy_done"}, {127'd0, bus.in_ready}, 128'd0);
        check({tag, "_adder_quiet"}, {bus.add_a, bus.add_b}, 128'd0);
    endtask

    task automatic take(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_vld_drop"}, {127'd0, bus.out_valid}, 128'd0);
        check({tag, "_rdy_back"}, {127'd0, bus.in_ready}, 128'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] held;
        bit           seen;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.x_in      = '0;
        bus.y_in      = '0;
`ifdef BOOTH_UNSIGNED_EN
        bus.is_signed = 1'b1;
`endif
        repeat (2) @(negedge clk);
        check("rst_vld", {127'd0, bus.out_valid}, 128'd0);
        check("rst_prod", bus.product, 128'd0);
        check("rst_rdy", {127'd0, bus.in_ready}, 128'd1);
        check("rst_adder", {bus.add_a, bus.add_b}, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("m3x5", 64'd3, 64'd5, 1'b1, 1'b0, 128'd15, 33);
        take("m3x5");
        run_op("m_1x_1", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 128'd1, 33);
        take("m_1x_1");
        run_op("m_7x6", 64'hFFFF_FFFF_FFFF_FFF9, 64'd6, 1'b1, 1'b1,
               128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFD6, 33);
        take("m_7x6");
        run_op("minxmin", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b0,
               128'h40000000_00000000_00000000_00000000, 33);
        take("minxmin");
        run_op("maxxmin", 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1, 1'b0,
               128'hC0000000_00000000_80000000_00000000, 33);

        held = 128'hC0000000_00000000_80000000_00000000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_prod", bus.product, held);
            check("stall_vld", {127'd0, bus.out_valid}, 128'd1);
            check("stall_rdy", {127'd0, bus.in_ready}, 128'd0);
        end
        take("stall");
        run_op("b2b", 64'd12345, 64'hFFFF_FFFF_FFFF_FF9C, 1'b1, 1'b0,
               128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFED29BC, 33);
        take("b2b");

        bus.x_in     = 64'h0000_0001_2345_6789;
        bus.y_in     = 64'h0000_0000_00AB_CDEF;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (11) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_vld", {127'd0, bus.out_valid}, 128'd0);
        check("arst_prod", bus.product, 128'd0);
        check("arst_rdy", {127'd0, bus.in_ready}, 128'd1);
        check("arst_adder", {bus.add_a, bus.add_b}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("arst_no_pulse", {127'd0, seen}, 128'd0);
        run_op("m2x_3", 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 1'b0,
               128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFA, 33);
        take("m2x_3");

`ifdef BOOTH_UNSIGNED_EN
        run_op("u_ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0,
               128'hFFFFFFFF_FFFFFFFE_00000000_00000001, 34);
        take("u_ones");
        run_op("s_ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 128'd1, 33);
        take("s_ones");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/booth_r4_seq_ctrl.md
Name: booth_r4_seq_ctrl

Overview:
- Sequential radix-4 Booth multiplier datapath and control. Sits directly upstream of the team's 66-bit lookahead adder (adder_66) and drives its A/B operands.
- Uses the adder's 66-bit sum as the accumulate step, one Booth digit per clock.
- Produces a 128-bit product from two 64-bit operands with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 64, operand width; must be even; accumulator/adder path is WIDTH+2 bits.
- ITER, WIDTH/2, Booth digits processed in signed mode (derived; not to be overridden).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- x_in  in  WIDTH  multiplicand, two's complement
- y_in  in  WIDTH  multiplier, two's complement
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- product  out  2*WIDTH  signed product x*y
- add_a  out  WIDTH+2  adder operand A (accumulator)
- add_b  out  WIDTH+2  adder operand B (selected partial product)
- add_s  in  WIDTH+2  adder sum, combinational return of add_a+add_b mod 2^(WIDTH+2)

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, out_valid=0, product=0, acc=0, counter=0, add_a=0, add_b=0. in_ready=1 (combinational, state==IDLE).
- States:
  - IDLE: in_ready=1. On in_valid, latch operands and go to CALC:
    - acc=0, Q=y_in, q_m1=0, cnt=0.
    - M1=sext(x_in), M2=M1<<1, N1=-M1, N2=N1<<1, all WIDTH+2 bits. Negation is done locally at load, because the adder has no carry-in.
  - CALC: one digit per cycle.
    - Booth digit {Q[1],Q[0],q_m1}: 000/111→0, 001/010→M1, 011→M2, 100→N2, 101/110→N1.
    - add_a=acc, add_b=selected multiple, both combinational from registers.
    - Update: {acc,Q,q_m1} <= arithmetic shift right by 2 of {add_s,Q,q_m1}; the sign bit add_s[WIDTH+1] is replicated. Then cnt++.
    - When cnt==ITER-1, the update is performed and the state goes to DONE.
  - DONE: product={acc[WIDTH-1:0],Q} is registered on entry; out_valid=1. Hold product and out_valid until out_ready=1, then out_valid<=0 and go to IDLE.
- Latency: handshake in cycle 0, ITER CALC cycles, out_valid asserted in cycle ITER+1 (33 for WIDTH=64). Throughput: one product per ITER+2 cycles minimum.
- Adder carry-out is ignored; all arithmetic is modulo 2^(WIDTH+2). WIDTH+2 bits hold ±2M without overflow for every signed input, including x=-2^(WIDTH-1).
- in_valid is ignored outside IDLE. Operands must not be sampled again during CALC.
- out_ready while out_valid=0 has no effect. out_valid and in_ready are never both 1.
- add_b=0 and add_a=0 in IDLE and DONE, so the adder is quiet.
- Asynchronous reset mid-CALC or in DONE: immediate return to reset values. The partial result is discarded and no out_valid pulse is produced.

Optional Feature:
- Macro BOOTH_UNSIGNED_EN.
- When defined:
  - Adds input is_signed (1 bit), sampled at the in_valid handshake.
  - is_signed=0: operands are zero-extended. M1=zext(x_in); Q is extended by 2 zero bits; ITER+1 iterations. Product = low 2*WIDTH bits of the result; out_valid in cycle ITER+2.
  - is_signed=1: behaviour identical to the macro-off build.
- When not defined: no is_signed port; always signed; fixed ITER iterations.

Test Plan:
- x=3, y=5 → product=15, out_valid exactly 33 cycles after the handshake.
- x=-1, y=-1 → product=1; x=-7, y=6 → product=-42 (0xFFFF…FFD6).
- x=y=0x8000_0000_0000_0000 → product=0x4000_0000_0000_0000_0000_0000_0000_0000. x=0x7FFF_FFFF_FFFF_FFFF, y=0x8000…0 → product=0xC000…0000_8000_0000_0000_0000.
- out_ready held 0 for 10 cycles after out_valid → product and out_valid stable, in_ready=0. Then out_ready=1 → one transfer, next cycle in_ready=1. A back-to-back second op returns the correct product.
- rst_n pulsed low at CALC cycle 12 → out_valid=0, product=0, in_ready=1 immediately. A subsequent op x=2, y=-3 → -6.
- BOOTH_UNSIGNED_EN, is_signed=0, x=y=0xFFFF_FFFF_FFFF_FFFF → product=0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, out_valid after 34 cycles.
